// File: rtl/alu_arbiter_if.sv
// Request, ALU-side and response signals shared by the arbiter and its neighbours.
// slave is the arbiter's view. master is the view of the requesters, the ALU and the consumer.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_x;
  logic [31:0] req0_y;
  logic [3:0]  req0_sel;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_x;
  logic [31:0] req1_y;
  logic [3:0]  req1_sel;

  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [3:0]  alu_sel;
  logic [31:0] alu_result;
  logic [31:0] alu_result2;
  logic        alu_of;
  logic        alu_cf;
  logic        alu_equal;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic [31:0] rsp_result2;
  logic        rsp_of;
  logic        rsp_cf;
  logic        rsp_equal;
  logic        rsp_dz;
  logic        rsp_illegal;
  logic        busy;

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_sel,
    output req0_ready,
    input  req1_valid, req1_x, req1_y, req1_sel,
    output req1_ready,
    output alu_x, alu_y, alu_sel,
    input  alu_result, alu_result2, alu_of, alu_cf, alu_equal,
    output rsp_valid, rsp_id, rsp_result, rsp_result2,
    output rsp_of, rsp_cf, rsp_equal, rsp_dz, rsp_illegal,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_x, req0_y, req0_sel,
    input  req0_ready,
    output req1_valid, req1_x, req1_y, req1_sel,
    input  req1_ready,
    input  alu_x, alu_y, alu_sel,
    output alu_result, alu_result2, alu_of, alu_cf, alu_equal,
    input  rsp_valid, rsp_id, rsp_result, rsp_result2,
    input  rsp_of, rsp_cf, rsp_equal, rsp_dz, rsp_illegal,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, with a tagged response channel.
// Latency: the response is valid ALU_CYCLES or MULDIV_CYCLES cycles after accept; issue-to-issue spacing is at least LAT+2.
// Backpressure: requests are accepted only in IDLE. A stalled response (rsp_ready low) holds the unit in RESP indefinitely.
module alu_arbiter #(
  parameter int MULDIV_CYCLES = 4,
  parameter int ALU_CYCLES    = 1
) (
  input  logic clk,
  input  logic rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant;
  logic        grant;
  logic        id_q;
  logic [3:0]  cnt_q;
  logic        accept;
  logic        capture;

  logic [31:0] acc_x, acc_y;
  logic [3:0]  acc_sel;
  logic        acc_muldiv;

  logic [31:0] alu_x_q, alu_y_q;
  logic [3:0]  alu_sel_q;

  logic        rsp_valid_q, rsp_id_q;
  logic [31:0] rsp_result_q, rsp_result2_q;
  logic        rsp_of_q, rsp_cf_q, rsp_equal_q, rsp_dz_q, rsp_illegal_q;

  logic [31:0] cap_result, cap_result2;
  logic        cap_of, cap_cf, cap_equal, cap_dz, cap_illegal;

  // Grant: a single valid port wins outright; on a tie the port that did not win last time goes.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else if (bus.req1_valid)              grant = 1'b1;
  end

  assign bus.req0_ready = (state_q == IDLE) && !grant;
  assign bus.req1_ready = (state_q == IDLE) &&  grant;
  assign accept  = grant ? (bus.req1_valid && bus.req1_ready) : (bus.req0_valid && bus.req0_ready);
  assign capture = (state_q == EXEC) && (cnt_q == 4'd0);

  // Operand mux for the granted port. Mul and div need the longer settling window.
  always_comb begin
    acc_x      = grant ? bus.req1_x   : bus.req0_x;
    acc_y      = grant ? bus.req1_y   : bus.req0_y;
    acc_sel    = grant ? bus.req1_sel : bus.req0_sel;
    acc_muldiv = (acc_sel == 4'd3) || (acc_sel == 4'd4);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (rsp_valid_q && bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Arbitration history, requester tag and the settling counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      cnt_q      <= 4'd0;
    end else if (accept) begin
      last_grant <= grant;
      id_q       <= grant;
      cnt_q      <= acc_muldiv ? 4'(MULDIV_CYCLES - 1) : 4'(ALU_CYCLES - 1);
    end else if ((state_q == EXEC) && (cnt_q != 4'd0)) begin
      cnt_q      <= cnt_q - 4'd1;
    end
  end

  // ALU operand registers: loaded on accept and deliberately left holding the last operands afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_x_q   <= '0;
      alu_y_q   <= '0;
      alu_sel_q <= '0;
    end else if (accept) begin
      alu_x_q   <= acc_x;
      alu_y_q   <= acc_y;
      alu_sel_q <= acc_sel;
    end
  end

  // Capture values: divide-by-zero and illegal selects override whatever the ALU produced.
  always_comb begin
    cap_result  = bus.alu_result;
    cap_result2 = bus.alu_result2;
    cap_of      = bus.alu_of;
    cap_cf      = bus.alu_cf;
    cap_equal   = bus.alu_equal;
    cap_dz      = 1'b0;
    cap_illegal = 1'b0;
    if (alu_sel_q > 4'd12) begin
      cap_result  = '0;
      cap_result2 = '0;
      cap_of      = 1'b0;
      cap_cf      = 1'b0;
      cap_equal   = 1'b0;
      cap_illegal = 1'b1;
    end else if ((alu_sel_q == 4'd4) && (alu_y_q == 32'd0)) begin
      cap_result  = 32'hFFFF_FFFF;
      cap_result2 = alu_x_q;
      cap_of      = 1'b0;
      cap_cf      = 1'b0;
      cap_equal   = 1'b0;
      cap_dz      = 1'b1;
    end
  end

  // Response registers: filled at the end of EXEC and held until the consumer takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= '0;
      rsp_result2_q <= '0;
      rsp_of_q      <= 1'b0;
      rsp_cf_q      <= 1'b0;
      rsp_equal_q   <= 1'b0;
      rsp_dz_q      <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else if (capture) begin
      rsp_valid_q   <= 1'b1;
      rsp_id_q      <= id_q;
      rsp_result_q  <= cap_result;
      rsp_result2_q <= cap_result2;
      rsp_of_q      <= cap_of;
      rsp_cf_q      <= cap_cf;
      rsp_equal_q   <= cap_equal;
      rsp_dz_q      <= cap_dz;
      rsp_illegal_q <= cap_illegal;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q   <= 1'b0;
    end
  end

  assign bus.alu_x       = alu_x_q;
  assign bus.alu_y       = alu_y_q;
  assign bus.alu_sel     = alu_sel_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_result2 = rsp_result2_q;
  assign bus.rsp_of      = rsp_of_q;
  assign bus.rsp_cf      = rsp_cf_q;
  assign bus.rsp_equal   = rsp_equal_q;
  assign bus.rsp_dz      = rsp_dz_q;
  assign bus.rsp_illegal = rsp_illegal_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed requests, a small ALU model, and an expected-response scoreboard.
// Expected responses are queued at accept time and checked on every response handshake.
// Latency, operand hold, stall, round-robin and reset-abort behaviour are checked inline.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_arbiter_if bus ();

  alu_arbiter #(.MULDIV_CYCLES(4), .ALU_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [31:0] r;
    logic [31:0] r2;
    logic        of;
    logic        cf;
    logic        eq;
    logic        dz;
    logic        ill;
  } rsp_t;

  rsp_t sb[$];
  rsp_t exp_port[2];
  int   grants[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rsp   = 0;

  function automatic rsp_t mk(input logic id, input logic [31:0] r, input logic [31:0] r2,
                              input logic of, input logic cf, input logic eq,
                              input logic dz, input logic ill);
    rsp_t t;
    t.id = id; t.r = r; t.r2 = r2; t.of = of; t.cf = cf; t.eq = eq; t.dz = dz; t.ill = ill;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ALU model: 5 add, 3 mul, 4 div (with garbage on y==0), anything else xor/and with flags set.
  logic [63:0] prod;
  logic [32:0] sum;
  always_comb begin
    prod            = 64'(bus.alu_x) * 64'(bus.alu_y);
    sum             = 33'(bus.alu_x) + 33'(bus.alu_y);
    bus.alu_result  = bus.alu_x ^ bus.alu_y;
    bus.alu_result2 = bus.alu_x & bus.alu_y;
    bus.alu_of      = 1'b1;
    bus.alu_cf      = 1'b1;
    bus.alu_equal   = (bus.alu_x == bus.alu_y);
    case (bus.alu_sel)
      4'd5: begin
        bus.alu_result  = sum[31:0];
        bus.alu_result2 = 32'd0;
        bus.alu_cf      = sum[32];
        bus.alu_of      = (bus.alu_x[31] == bus.alu_y[31]) && (sum[31] != bus.alu_x[31]);
      end
      4'd3: begin
        bus.alu_result  = prod[31:0];
        bus.alu_result2 = prod[63:32];
        bus.alu_of      = 1'b0;
        bus.alu_cf      = 1'b0;
      end
      4'd4: begin
        bus.alu_of = 1'b0;
        bus.alu_cf = 1'b0;
        if (bus.alu_y != 32'd0) begin
          bus.alu_result  = bus.alu_x / bus.alu_y;
          bus.alu_result2 = bus.alu_x % bus.alu_y;
        end else begin
          bus.alu_result  = 32'hDEAD_BEEF;
          bus.alu_result2 = 32'h0000_1234;
          bus.alu_cf      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Accept monitor: queue the expected response of whichever port was taken.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req0_valid || bus.req1_valid)
        check("ready_exclusive", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
      if (bus.req0_valid && bus.req0_ready) begin
        sb.push_back(exp_port[0]);
        grants.push_back(0);
      end else if (bus.req1_valid && bus.req1_ready) begin
        sb.push_back(exp_port[1]);
        grants.push_back(1);
      end
    end
  end

  // Response monitor: compare every handshaken response with the head of the scoreboard.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got a response with id %0d, expected none", bus.rsp_id);
      end else begin
        e = sb.pop_front();
        check("rsp_id",      64'(bus.rsp_id),      64'(e.id));
        check("rsp_result",  64'(bus.rsp_result),  64'(e.r));
        check("rsp_result2", 64'(bus.rsp_result2), 64'(e.r2));
        check("rsp_flags",
              64'({bus.rsp_of, bus.rsp_cf, bus.rsp_equal, bus.rsp_dz, bus.rsp_illegal}),
              64'({e.of, e.cf, e.eq, e.dz, e.ill}));
      end
    end
  end

  task automatic drive_req(input int port, input logic v, input logic [31:0] x,
                           input logic [31:0] y, input logic [3:0] sel);
    if (port == 0) begin
      bus.req0_valid = v; bus.req0_x = x; bus.req0_y = y; bus.req0_sel = sel;
    end else begin
      bus.req1_valid = v; bus.req1_x = x; bus.req1_y = y; bus.req1_sel = sel;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    forever begin
      @(negedge clk);
      if (!bus.busy && !bus.rsp_valid) break;
      k++;
      if (k > 200) begin
        n_tests++; n_fail++;
        $display("FAIL wait_idle: still busy after %0d cycles, expected idle", k);
        break;
      end
    end
  endtask

  // Issue one uncontested request, then check the operand hold and the response latency.
  task automatic issue(input int port, input logic [31:0] x, input logic [31:0] y,
                       input logic [3:0] sel, input rsp_t e, input int lat);
    int k;
    exp_port[port] = e;
    @(posedge clk); #1;
    drive_req(port, 1'b1, x, y, sel);
    k = 0;
    forever begin
      @(negedge clk);
      if ((port == 0) ? bus.req0_ready : bus.req1_ready) break;
      k++;
      if (k > 50) break;
    end
    check("ready_first_cycle", 64'(k), 64'd0);
    @(posedge clk); #1;
    drive_req(port, 1'b0, 32'd0, 32'd0, 4'd0);
    k = 0;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      check("alu_x_hold",   64'(bus.alu_x),   64'(x));
      check("alu_y_hold",   64'(bus.alu_y),   64'(y));
      check("alu_sel_hold", 64'(bus.alu_sel), 64'(sel));
      k++;
      if (k > 100) break;
    end
    check("latency", 64'(k), 64'(lat));
  endtask

  // Hold both ports valid until n grants have been made.
  task automatic contend(input int n);
    int k = 0;
    forever begin
      @(negedge clk);
      if (grants.size() >= n) break;
      k++;
      if (k > 300) begin
        n_tests++; n_fail++;
        $display("FAIL contend: got %0d grants, expected %0d", grants.size(), n);
        break;
      end
    end
    @(posedge clk); #1;
    drive_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    drive_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    bus.rsp_ready = 1'b1;
    exp_port[0] = '0;
    exp_port[1] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_busy",      64'(bus.busy),       64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid),  64'd0);
    check("rst_alu_x",     64'(bus.alu_x),      64'd0);
    check("rst_alu_y",     64'(bus.alu_y),      64'd0);
    check("rst_alu_sel",   64'(bus.alu_sel),    64'd0);
    check("rst_rsp_res",   64'(bus.rsp_result), 64'd0);
    check("rst_rsp_id",    64'(bus.rsp_id),     64'd0);
    check("rst_req1_rdy",  64'(bus.req1_ready), 64'd0);

    // Single add on port 0, then a multiply on port 1.
    issue(0, 32'd5, 32'd7, 4'd5, mk(1'b0, 32'd12, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1);
    wait_idle();
    issue(1, 32'hFFFF_FFFF, 32'd2, 4'd3,
          mk(1'b1, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 4);
    wait_idle();

    // Both ports continuously valid: last grant was port 1, so 0,1,0,1.
    exp_port[0] = mk(1'b0, 32'd6, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_port[1] = mk(1'b1, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    grants.delete();
    @(posedge clk); #1;
    drive_req(0, 1'b1, 32'd3, 32'd3, 4'd5);
    drive_req(1, 1'b1, 32'h7FFF_FFFF, 32'd1, 4'd5);
    contend(4);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) check("rr_order", 64'(grants[i]), 64'(i % 2));
    wait_idle();

    // Divide by zero, then an illegal select.
    issue(0, 32'd9, 32'd0, 4'd4, mk(1'b0, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 4);
    wait_idle();
    issue(0, 32'd1, 32'd2, 4'd14, mk(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1);
    wait_idle();

    // Consumer stall: response held for 10 cycles with everything frozen.
    bus.rsp_ready = 1'b0;
    issue(1, 32'd10, 32'd3, 4'd4, mk(1'b1, 32'd3, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 4);
    for (int i = 0; i < 10; i++) begin
      check("stall_valid",   64'(bus.rsp_valid),   64'd1);
      check("stall_result",  64'(bus.rsp_result),  64'd3);
      check("stall_result2", 64'(bus.rsp_result2), 64'd1);
      check("stall_id",      64'(bus.rsp_id),      64'd1);
      check("stall_busy",    64'(bus.busy),        64'd1);
      check("stall_ready",   64'({bus.req0_ready, bus.req1_ready}), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_stall_busy",  64'(bus.busy),      64'd0);
    check("post_stall_valid", 64'(bus.rsp_valid), 64'd0);
    wait_idle();

    // Reset in the middle of a multiply: nothing is returned and arbitration restarts.
    exp_port[0] = mk(1'b0, 32'd42, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_req(0, 1'b1, 32'd6, 32'd7, 4'd3);
    k = 0;
    forever begin
      @(negedge clk);
      if (bus.req0_ready || k > 50) break;
      k++;
    end
    @(posedge clk); #1;
    drive_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    check("abort_busy_before", 64'(bus.busy), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_busy",      64'(bus.busy),      64'd0);
    check("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("abort_alu_x",     64'(bus.alu_x),     64'd0);
    check("abort_alu_y",     64'(bus.alu_y),     64'd0);
    check("abort_alu_sel",   64'(bus.alu_sel),   64'd0);

    exp_port[0] = mk(1'b0, 32'd4, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_port[1] = mk(1'b1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    grants.delete();
    @(posedge clk); #1;
    drive_req(0, 1'b1, 32'd2, 32'd2, 4'd5);
    drive_req(1, 1'b1, 32'd1, 32'd1, 4'd5);
    contend(1);
    if (grants.size() > 0) check("post_rst_tie", 64'(grants[0]), 64'd0);
    wait_idle();

    // Drain and account for every response.
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("sb_empty",  64'(sb.size()), 64'd0);
    check("rsp_count", 64'(n_rsp),     64'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
